// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage. Holds the program counter, issues the instruction
// memory read, and picks the next PC from:
//   - an execute-stage redirect,
//   - a branch-target-buffer prediction, or
//   - the sequential PC+4.
// A halt freezes the stage until reset.
//
// Optional feature macro: FETCH_BTB_EN
//   Builds a direct-mapped BTB with BTB_ENTRIES entries. When the macro is
//   not defined, no BTB is built: predicted_taken is tied to 0 and the
//   btb_update* ports are ignored.
//
// Ports:
//   CLK                in  1  : clock, rising edge
//   nRST               in  1  : asynchronous active-low reset
//   ihit               in  1  : memory returned the word at imemaddr
//   stall              in  1  : hazard unit holds IF/ID
//   halt               in  1  : halt instruction decoded
//   redirect           in  1  : restart fetch at redirect_pc
//   redirect_pc        in 32  : restart address (low two bits dropped)
//   btb_update         in  1  : write a BTB entry
//   btb_update_pc      in 32  : PC of the resolved taken branch
//   btb_update_target  in 32  : its taken target
//   imemREN            out 1  : instruction memory read enable
//   imemaddr           out 32 : current PC
//   npc                out 32 : PC+4, to IF/ID
//   predicted_taken    out 1  : next PC comes from a BTB hit
//   fetch_valid        out 1  : fetched word may be latched this cycle
//   fetch_count        out 32 : accepted fetches since reset
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] PC_INIT     = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        stall,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        btb_update,
  input  logic [31:0] btb_update_pc,
  input  logic [31:0] btb_update_target,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] npc,
  output logic        predicted_taken,
  output logic        fetch_valid,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic        running;
  logic        fetch_ok;
  logic        btb_hit;
  logic [31:0] btb_target;

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next state. A halt that arrives together with a redirect came from the
  // wrong path and is discarded.
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && halt && !redirect) state_d = HALTED;
  end

  // FSM outputs.
  always_comb begin
    running  = (state_q == RUN);
    imemREN  = running;
    fetch_ok = running & ihit & ~stall & ~redirect;
  end

  // PC and fetch counter next values. A redirect wins even when stalled or
  // waiting on memory. Nothing changes once halted.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    if (running) begin
      if (redirect)      pc_d = {redirect_pc[31:2], 2'b00};
      else if (fetch_ok) pc_d = btb_hit ? btb_target : pc_q + 32'd4;
    end
    if (fetch_ok) count_d = count_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q    <= PC_INIT;
      count_q <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign imemaddr        = pc_q;
  assign npc             = pc_q + 32'd4;
  assign fetch_valid     = fetch_ok;
  assign fetch_count     = count_q;
  assign predicted_taken = btb_hit;

`ifdef FETCH_BTB_EN
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             btb_valid_q [BTB_ENTRIES];
  logic             btb_valid_d [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_q   [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_d   [BTB_ENTRIES];
  logic [29:0]      btb_tgt_q   [BTB_ENTRIES];
  logic [29:0]      btb_tgt_d   [BTB_ENTRIES];
  logic [IDX_W-1:0] look_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             unused_btb_low;

  assign look_idx       = pc_q[IDX_W+1:2];
  assign upd_idx        = btb_update_pc[IDX_W+1:2];
  assign unused_btb_low = ^{btb_update_pc[1:0], btb_update_target[1:0]};

  // Lookup reads the registered table, so a same-cycle update to the same
  // index is only seen from the next cycle on.
  always_comb begin
    btb_hit    = btb_valid_q[look_idx] && (btb_tag_q[look_idx] == pc_q[31:IDX_W+2]);
    btb_target = {btb_tgt_q[look_idx], 2'b00};
  end

  // Table write; targets are stored word-aligned.
  always_comb begin
    btb_valid_d = btb_valid_q;
    btb_tag_d   = btb_tag_q;
    btb_tgt_d   = btb_tgt_q;
    if (running && btb_update) begin
      btb_valid_d[upd_idx] = 1'b1;
      btb_tag_d[upd_idx]   = btb_update_pc[31:IDX_W+2];
      btb_tgt_d[upd_idx]   = btb_update_target[31:2];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_q[i] <= 1'b0;
        btb_tag_q[i]   <= '0;
        btb_tgt_q[i]   <= '0;
      end
    end else begin
      btb_valid_q <= btb_valid_d;
      btb_tag_q   <= btb_tag_d;
      btb_tgt_q   <= btb_tgt_d;
    end
  end
`else
  localparam int unused_btb_entries = BTB_ENTRIES;
  logic unused_btb_ports;

  assign unused_btb_ports = ^{btb_update, btb_update_pc, btb_update_target};
  assign btb_hit          = 1'b0;
  assign btb_target       = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit with PC_INIT = 0 and four BTB entries.
// Covers reset values, sequential fetch, stall, redirect under stall and
// under ihit, address wrap, halt, halt-with-redirect, asynchronous reset,
// and BTB prediction (or its absence in the default build).
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, stall, halt, redirect;
  logic [31:0] redirect_pc;
  logic        btb_update;
  logic [31:0] btb_update_pc, btb_update_target;
  logic        imemREN;
  logic [31:0] imemaddr, npc;
  logic        predicted_taken, fetch_valid;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .PC_INIT     (32'h0000_0000),
    .BTB_ENTRIES (4)
  ) dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .ihit              (ihit),
    .stall             (stall),
    .halt              (halt),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .btb_update        (btb_update),
    .btb_update_pc     (btb_update_pc),
    .btb_update_target (btb_update_target),
    .imemREN           (imemREN),
    .imemaddr          (imemaddr),
    .npc               (npc),
    .predicted_taken   (predicted_taken),
    .fetch_valid       (fetch_valid),
    .fetch_count       (fetch_count)
  );

  always #5 CLK = ~CLK;

  // Drive the fetch-control inputs.
  task automatic applyStimulus(input logic i_ihit, input logic i_stall,
                               input logic i_halt, input logic i_redirect,
                               input logic [31:0] i_redirect_pc);
    ihit        = i_ihit;
    stall       = i_stall;
    halt        = i_halt;
    redirect    = i_redirect;
    redirect_pc = i_redirect_pc;
  endtask

  // One active edge, then settle away from it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    nRST              = 1'b0;
    btb_update        = 1'b0;
    btb_update_pc     = 32'h0;
    btb_update_target = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("reset_imemaddr", imemaddr, 32'h0);
    checkOutput("reset_npc", npc, 32'h4);
    checkOutput("reset_imemREN", {31'b0, imemREN}, 32'h1);
    checkOutput("reset_pred", {31'b0, predicted_taken}, 32'h0);
    checkOutput("reset_count", fetch_count, 32'h0);
    checkOutput("reset_valid", {31'b0, fetch_valid}, 32'h0);

    #1 nRST = 1'b1;

    // Sequential fetch: 0 -> 4 -> 8 -> C.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #0;
    checkOutput("seq_valid", {31'b0, fetch_valid}, 32'h1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput("seq_addr", imemaddr, 32'(4 * i));
      checkOutput("seq_npc", npc, 32'(4 * i + 4));
    end
    checkOutput("seq_count", fetch_count, 32'd3);

    // Hold without ihit.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("nohit_hold", imemaddr, 32'hC);

    // One more fetch to reach 0x10, then stall for two cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("pre_stall_addr", imemaddr, 32'h10);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    #0;
    checkOutput("stall_valid", {31'b0, fetch_valid}, 32'h0);
    tick();
    checkOutput("stall_hold1", imemaddr, 32'h10);
    tick();
    checkOutput("stall_hold2", imemaddr, 32'h10);
    checkOutput("stall_count", fetch_count, 32'd4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("stall_resume", imemaddr, 32'h14);
    checkOutput("resume_count", fetch_count, 32'd5);

    // Redirect while stalled and without ihit; low bits dropped.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0103);
    #0;
    checkOutput("redir_stall_valid", {31'b0, fetch_valid}, 32'h0);
    tick();
    checkOutput("redir_stall_addr", imemaddr, 32'h100);

    // Redirect with ihit squashes the word and does not count it.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    #0;
    checkOutput("redir_hit_valid", {31'b0, fetch_valid}, 32'h0);
    tick();
    checkOutput("wrap_addr", imemaddr, 32'hFFFF_FFFC);
    checkOutput("wrap_npc", npc, 32'h0);
    checkOutput("redir_count", fetch_count, 32'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("wrap_pc", imemaddr, 32'h0);
    checkOutput("wrap_count", fetch_count, 32'd6);

    // Halt together with redirect: redirect wins, stays RUN.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
    tick();
    checkOutput("halt_redir_addr", imemaddr, 32'h40);
    checkOutput("halt_redir_ren", {31'b0, imemREN}, 32'h1);

    // Move to 0x20 and halt there.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("halt_ren", {31'b0, imemREN}, 32'h0);
    checkOutput("halt_addr", imemaddr, 32'h20);

    // Everything is ignored while halted.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
    btb_update = 1'b1;
    btb_update_pc = 32'h20;
    btb_update_target = 32'h300;
    #0;
    checkOutput("halted_valid", {31'b0, fetch_valid}, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("halted_addr", imemaddr, 32'h20);
    checkOutput("halted_count", fetch_count, 32'd6);
    checkOutput("halted_pred", {31'b0, predicted_taken}, 32'h0);
    btb_update = 1'b0;

    // Asynchronous reset mid-cycle, checked before any clock edge.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2 nRST = 1'b0;
    #1;
    checkOutput("areset_addr", imemaddr, 32'h0);
    checkOutput("areset_ren", {31'b0, imemREN}, 32'h1);
    checkOutput("areset_count", fetch_count, 32'h0);
    #1 nRST = 1'b1;

    // Write a BTB entry for pc 0x8 -> 0x80, then fetch up to 0x8.
    btb_update        = 1'b1;
    btb_update_pc     = 32'h8;
    btb_update_target = 32'h83;
    tick();
    btb_update = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("btb_at8", imemaddr, 32'h8);
`ifdef FETCH_BTB_EN
    checkOutput("btb_hit", {31'b0, predicted_taken}, 32'h1);
    tick();
    checkOutput("btb_target", imemaddr, 32'h80);
    // Same index, different tag: no hit.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h18);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #0;
    checkOutput("btb_tagmiss", {31'b0, predicted_taken}, 32'h0);
    tick();
    checkOutput("btb_miss_next", imemaddr, 32'h1C);
`else
    checkOutput("nobtb_pred", {31'b0, predicted_taken}, 32'h0);
    tick();
    checkOutput("nobtb_next", imemaddr, 32'hC);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined core. Holds the program counter, drives the instruction-memory request, and selects the next PC from sequential increment, an optional branch-target-buffer prediction, or a redirect from the execute stage. Its `npc` output and the instruction word returned by memory feed the IF/ID pipeline latch directly downstream. `fetch_valid` tells that latch when a fetched word may be captured.

## Interface
Parameters:
- `PC_INIT`, 32'h0000_0000, PC value loaded on reset.
- `BTB_ENTRIES`, 4, number of BTB entries; power of two, ≥2. Used only with `FETCH_BTB_EN`.

Ports:
- `CLK` in 1: clock, rising-edge active.
- `nRST` in 1: reset, asynchronous, active-low.
- `ihit` in 1: instruction memory has returned the word at `imemaddr` this cycle.
- `stall` in 1: hazard unit holds IF/ID; PC must not advance.
- `halt` in 1: halt instruction decoded.
- `redirect` in 1: branch/jump resolved against the prediction; fetch must restart at `redirect_pc`.
- `redirect_pc` in 32: restart address.
- `btb_update` in 1: write a BTB entry (taken branch/jump resolved).
- `btb_update_pc` in 32: PC of that branch.
- `btb_update_target` in 32: its taken target.
- `imemREN` out 1: instruction-memory read enable.
- `imemaddr` out 32: fetch address (current PC).
- `npc` out 32: PC+4 of the current fetch, to IF/ID.
- `predicted_taken` out 1: next PC came from a BTB hit.
- `fetch_valid` out 1: fetched word may be latched this cycle.
- `fetch_count` out 32: number of accepted fetches since reset.

## Operation
- States: RUN, HALTED. Reset → RUN. RUN → HALTED on edge with `halt`=1 and `redirect`=0. HALTED is left only by reset.
- `imemaddr` = PC. `npc` = PC+4, modulo 2^32, so 32'hFFFF_FFFC gives 0.
- `imemREN` = 1 in RUN and 0 in HALTED.
- `fetch_valid` = RUN & `ihit` & ~`stall` & ~`redirect`.
- PC next-value priority, evaluated at each edge:
  1. `redirect`: PC ← {`redirect_pc`[31:2],2'b00}. This applies in any RUN condition, including `stall`=1 or `ihit`=0.
  2. `fetch_valid`: PC ← predicted target if there is a BTB hit, otherwise PC+4.
  3. Otherwise PC holds.
- In HALTED, PC, BTB and `fetch_count` are frozen. All inputs are ignored.
- `redirect` and `halt` in the same cycle: redirect wins and the state stays RUN, because the halt was on the wrong path.
- `fetch_count` increments by 1 at each edge where `fetch_valid`=1 and wraps at 2^32.

## Timing
- Reset values, asynchronous: PC=`PC_INIT`, state RUN, `fetch_count`=0, all BTB valid bits 0. As a result `imemaddr`=`PC_INIT`, `npc`=`PC_INIT`+4, `imemREN`=1 and `predicted_taken`=0.
- All outputs except the registered PC and `fetch_count` are combinational from the current state and inputs. There is no added latency.
- Redirect latency is one edge: `imemaddr` shows the target in the cycle after `redirect` is sampled. The redirect cycle itself produces `fetch_valid`=0, which squashes the wrong-path word.
- With `ihit`=0, PC holds indefinitely. No timeout.
- Reset asserted mid-operation returns every register to its reset value immediately, without waiting for `CLK`.

## Configuration
- `FETCH_BTB_EN` defined:
  - Direct-mapped BTB with `BTB_ENTRIES` entries.
  - Index = PC[log2(N)+1:2]; tag = PC[31:log2(N)+2].
  - Lookup on the current PC gives a hit when the entry is valid and the tag matches. A hit sets `predicted_taken`=1 and supplies the target.
  - On an edge with `btb_update`=1, the entry indexed by `btb_update_pc` gets valid=1, its tag, and `btb_update_target` with bits [1:0] forced to 0. An existing entry is overwritten.
  - When a lookup and an update hit the same index in the same cycle, the lookup sees the old contents.
- `FETCH_BTB_EN` undefined:
  - No BTB storage is built.
  - `predicted_taken` is tied 0 and the sequential next PC is always PC+4.
  - The `btb_update*` ports are ignored.

## Test plan
- Reset with `PC_INIT`=0, then `ihit`=1 for 3 cycles → `imemaddr` steps 0,4,8,C; `fetch_count`=3; `npc` tracks `imemaddr`+4.
- `stall`=1 for 2 cycles at PC=0x10 with `ihit`=1 → PC holds at 0x10 and `fetch_valid`=0; resumes at 0x14 after `stall` drops.
- `redirect`=1 with `redirect_pc`=0x0000_0103 while `stall`=1 and `ihit`=0 → next cycle `imemaddr`=0x100; the redirect cycle has `fetch_valid`=0.
- `halt`=1 at PC=0x20 → HALTED with `imemREN`=0; PC stays 0x20 for 10 cycles. In a separate run, `halt`=1 together with `redirect` to 0x40 → stays RUN with PC=0x40.
- PC forced to 0xFFFF_FFFC via redirect, then one `ihit` → PC=0 and `npc` was 0.
- `FETCH_BTB_EN`: update entry for pc 0x8 with target 0x80, then fetch at 0x8 → `predicted_taken`=1 and next PC 0x80. Fetch at 0x18 (same index, different tag) → no hit and next PC 0x1C.
